// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage F/D/E/M/W core.
//   - Selects the E-stage operand forwarding source per channel (M over W).
//   - Inserts a configurable number of load-use bubbles.
//   - Freezes the whole pipe while the M-stage memory access waits for ack,
//     then resumes whatever it was doing (RUN or a partly done load-use).
//   - Counts the cycles in which the D stage is held (saturating).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cmd_e, cmd_m            stage command (11=LW, 10=ST, 01=JMP, 00=other)
//   rs_d, rs_e              packed source addresses, channel i at [i*AW +: AW]
//   rd_e/m/w, we_e/m/w      destination register and write enable per stage
//   redirect_e              taken branch/jump resolved in E
//   mem_ack                 data memory acknowledge for the M-stage access
//   fwd_sel_e               per channel 00=regfile, 01=from M, 10=from W
//   en_f..en_w              stage-register load enables
//   flush_d/e/m             stage-register clears
//   stall_cnt               saturating count of cycles with en_d=0
//   state                   00=RUN, 01=LU_STALL, 10=MEM_WAIT
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int AW         = 5,
  parameter int NUM_RS     = 2,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             cmd_e,
  input  logic [1:0]             cmd_m,
  input  logic [NUM_RS*AW-1:0]   rs_d,
  input  logic [NUM_RS*AW-1:0]   rs_e,
  input  logic [AW-1:0]          rd_e,
  input  logic [AW-1:0]          rd_m,
  input  logic [AW-1:0]          rd_w,
  input  logic                   we_e,
  input  logic                   we_m,
  input  logic                   we_w,
  input  logic                   redirect_e,
  input  logic                   mem_ack,
  output logic [NUM_RS*2-1:0]    fwd_sel_e,
  output logic                   en_f,
  output logic                   en_d,
  output logic                   en_e,
  output logic                   en_m,
  output logic                   en_w,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic                   flush_m,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_LU  = 2'b01,
    ST_MW  = 2'b10
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic             resume_q, resume_d;   // 1: resume into LU_STALL, 0: RUN
  logic [CNT_W-1:0] stall_cnt_q;

  logic   mem_stall_s;
  logic   lu_hit_s;
  logic   br_s;
  state_t eff_state_s;

  assign mem_stall_s = cmd_m[1] & ~mem_ack;
  assign br_s        = (cmd_e == 2'b01) & redirect_e;

  // On the ack cycle of a memory wait the controller behaves exactly as the
  // state it is resuming, so held redirects and load-use counts carry on.
  assign eff_state_s = ((state_q == ST_MW) && mem_ack) ?
                       (resume_q ? ST_LU : ST_RUN) : state_q;

  // Load-use hazard: a load in E writes a register some D-stage source reads.
  always_comb begin
    lu_hit_s = 1'b0;
    if ((cmd_e == 2'b11) && we_e && (rd_e != '0)) begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (rs_d[i*AW +: AW] == rd_e) lu_hit_s = 1'b1;
      end
    end else begin
      lu_hit_s = 1'b0;
    end
  end

  // State, load-use counter and resume target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      lu_cnt_q <= 3'd0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      resume_q <= resume_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    resume_d = resume_q;
    case (eff_state_s)
      ST_RUN: begin
        if (mem_stall_s) begin
          state_d  = ST_MW;
          resume_d = 1'b0;
        end else if (lu_hit_s && (LU_BUBBLES > 1)) begin
          state_d  = ST_LU;
          lu_cnt_d = LU_INIT;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_LU: begin
        if (mem_stall_s) begin
          state_d  = ST_MW;
          resume_d = 1'b1;
        end else begin
          lu_cnt_d = lu_cnt_q - 3'd1;
          state_d  = (lu_cnt_q == 3'd1) ? ST_RUN : ST_LU;
        end
      end
      ST_MW: begin
        state_d = ST_MW;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stage enables and flushes; reset forces a full flush with everything held.
  always_comb begin
    {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
    {flush_d, flush_e, flush_m}    = 3'b000;
    if (reset) begin
      {flush_d, flush_e, flush_m} = 3'b111;
    end else begin
      case (eff_state_s)
        ST_RUN: begin
          if (mem_stall_s) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
          end else if (lu_hit_s) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00111;
            flush_e = 1'b1;
          end else if (br_s) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b11111;
            {flush_d, flush_e}             = 2'b11;
          end else begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b11111;
          end
        end
        ST_LU: begin
          if (mem_stall_s) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
          end else begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00111;
            flush_e = 1'b1;
          end
        end
        default: begin
          {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
        end
      endcase
    end
  end

  // Operand forwarding select per E-stage source channel, M before W.
  always_comb begin
    fwd_sel_e = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (rs_e[i*AW +: AW] == '0) begin
          fwd_sel_e[i*2 +: 2] = 2'b00;
        end else if (we_m && (rd_m == rs_e[i*AW +: AW])) begin
          fwd_sel_e[i*2 +: 2] = 2'b01;
        end else if (we_w && (rd_w == rs_e[i*AW +: AW])) begin
          fwd_sel_e[i*2 +: 2] = 2'b10;
        end else begin
          fwd_sel_e[i*2 +: 2] = 2'b00;
        end
      end
    end else begin
      fwd_sel_e = '0;
    end
  end

  // Saturating count of cycles in which D is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!en_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign state     = state_q;

endmodule
